alu_unit: RTL
=============

# alu_unit

Integer execution unit fed by the reservation station's issue port. It accepts at most one operation per cycle, evaluates RV32I arithmetic, logic, shift, compare, branch and jump ops, and drives the ALU leg of the CDB (`alu_broadcast`, `alu_entry`, `alu_value`, `alu_pc_out`). The CDB leg is consumed by the reservation station, the load/store buffer and the ROB. Throughput is one op per cycle and there is no back-pressure; the unit flushes on misprediction rollback.

## Interface
- `ENTRY_W`, default width of `` `ENTRY_RANGE ``: ROB tag width. `` `ENTRY_NULL `` denotes no tag.
- `clk_in` in 1: the single clock.
- `rst_in` in 1: asynchronous, active-low reset.
- `rdy_in` in 1: when low, the unit pauses and holds all state.
- `roll_back` in 1: misprediction flush.
- `new_calculate` in 1: issue valid.
- `rs_op_out` in 6: op code as defined in operaType.v.
- `rs_instruct_out` in 32: raw instruction, carried through only.
- `rs_vj_out`, `rs_vk_out` in 32 each: rs1 and rs2 values.
- `rs_imm_out` in 32: sign-extended immediate.
- `rs_pc_out` in 32: PC of the instruction.
- `rs_entry_out` in ENTRY_W: ROB tag.
- `alu_broadcast` out 1: result valid on the CDB.
- `alu_entry` out ENTRY_W: tag of the result.
- `alu_value` out 32: rd value. For branches, bit0 is the taken flag.
- `alu_pc_out` out 32: next PC of the instruction.
- `alu_jump` out 1: control transfer taken (JAL, JALR, taken branch).
- `alu_busy` out 1: at least one stage holds a valid op.

## Operation
- Stage S1 (present only with ALU_PIPE_EN) registers the issue bundle plus a valid bit.
- Stage S2 computes the result and registers the CDB outputs.
- Arithmetic:
  - All sums wrap modulo 2^32.
  - Shifts use the low 5 bits of the operand.
  - SRA/SRAI are arithmetic shifts.
  - SLT/SLTI/BLT/BGE compare signed; SLTU/SLTIU/BLTU/BGEU compare unsigned.
- Operand selection: I-type ops use `imm` as the second operand; R-type ops use `vk`.
- LUI: value = imm, next PC = pc+4.
- AUIPC: value = pc+imm, next PC = pc+4.
- JAL: value = pc+4, next PC = pc+imm, jump = 1.
- JALR: value = pc+4, next PC = (vj+imm) & ~1, jump = 1.
- Branches: value = {31'b0, taken}; next PC = taken ? pc+imm : pc+4; jump = taken.
- All other ops: next PC = pc+4, jump = 0.
- Unrecognised op: value = 0, next PC = pc+4, jump = 0. The op is still broadcast so the ROB entry retires.
- `alu_entry` always equals the issued tag. Ops never reorder.
- Reset: all valid bits, `alu_broadcast`, `alu_jump` and `alu_busy` = 0; `alu_value` and `alu_pc_out` = 0; `alu_entry` = `` `ENTRY_NULL ``.
- Rollback (synchronous, highest priority after reset):
  - Clears every valid bit.
  - `alu_broadcast` is 0 from the next edge.
  - An issue arriving in the same cycle as rollback is dropped.
  - Data registers may keep stale values; `alu_entry` is forced to `` `ENTRY_NULL ``.
- `rdy_in` low: every register holds, including `alu_broadcast`. `new_calculate` is ignored. Consumers are also paused, so a held broadcast is not double-counted.
- Reset asserted mid-operation discards all in-flight ops immediately (asynchronous).

## Timing
- Issue sampled at posedge k with `new_calculate` = 1 and `rdy_in` = 1.
- With ALU_PIPE_EN: S1 loads at k, result registered at k+1, `alu_broadcast` high during cycle k+1 to k+2. Latency is 2 edges.
- Without ALU_PIPE_EN: result registered at k, broadcast during k to k+1. Latency is 1 edge.
- Back-to-back issue on every edge gives back-to-back broadcasts with no bubbles.
- `alu_broadcast` is high for exactly one active cycle per op.
- `alu_busy` is registered and reflects the valid bits after each edge.

## Configuration
- `ALU_PIPE_EN`:
  - Defined: two-stage pipeline (S1 operand register, S2 compute/output), 2-edge latency, shorter critical path.
  - Undefined: S1 is removed, compute feeds the output registers directly, 1-edge latency.
  - Functional results, ordering and flush rules are identical in both builds.

## Test plan
- Reset then idle:
  - Hold `rst_in` = 0 for 3 cycles, release, keep `new_calculate` = 0.
  - Required: `alu_broadcast` = 0, `alu_busy` = 0, `alu_entry` = `` `ENTRY_NULL `` on every cycle.
- ADD wrap:
  - Issue ADD, vj = 32'hFFFF_FFFF, vk = 2, pc = 32'h100, tag 5.
  - Required: after the configured latency, one broadcast with value 1, next PC 32'h104, entry 5, jump 0.
- Branch and JALR:
  - Issue BLT, vj = -1, vk = 1, imm = 16, pc = 32'h200, then BLTU with the same operands on the next cycle.
  - Required: BLT broadcasts value 1, next PC 32'h210, jump 1; BLTU broadcasts value 0, next PC 32'h204, jump 0; broadcasts arrive back-to-back.
  - Issue JALR, vj = 32'h301, imm = 2.
  - Required: value = pc+4, next PC 32'h302.
- Shift masking:
  - Issue SRA, vj = 32'h8000_0000, vk = 33.
  - Required: value 32'hC000_0000.
- Rollback:
  - Issue tags 1, 2, 3 on consecutive cycles, with `roll_back` high in the cycle tag 3 is issued.
  - Required (ALU_PIPE_EN build): tag 1 broadcasts; tags 2 and 3 never broadcast; `alu_busy` = 0 after the rollback edge.
- Pause:
  - Issue tag 7, then hold `rdy_in` low for 3 cycles while its broadcast is high.
  - Required: outputs frozen at tag 7 throughout. After `rdy_in` returns, tag 7 is dropped after one active cycle, and a `new_calculate` pulse during the pause produces no broadcast.

Source files
------------

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - RV32I integer execution unit driving the ALU leg of the CDB (optional macro: ALU_PIPE_EN)
module alu_unit #(
  parameter int                 ENTRY_W    = 5,
  parameter logic [ENTRY_W-1:0] ENTRY_NULL = '0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               roll_back,
  input  logic               new_calculate,
  input  logic [5:0]         rs_op_out,
  input  logic [31:0]        rs_instruct_out,
  input  logic [31:0]        rs_vj_out,
  input  logic [31:0]        rs_vk_out,
  input  logic [31:0]        rs_imm_out,
  input  logic [31:0]        rs_pc_out,
  input  logic [ENTRY_W-1:0] rs_entry_out,
  output logic               alu_broadcast,
  output logic [ENTRY_W-1:0] alu_entry,
  output logic [31:0]        alu_value,
  output logic [31:0]        alu_pc_out,
  output logic               alu_jump,
  output logic               alu_busy
);

  // Op codes shared with the reservation station decoder
  localparam logic [5:0] OP_LUI   = 6'd1;
  localparam logic [5:0] OP_AUIPC = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_JALR  = 6'd4;
  localparam logic [5:0] OP_BEQ   = 6'd5;
  localparam logic [5:0] OP_BNE   = 6'd6;
  localparam logic [5:0] OP_BLT   = 6'd7;
  localparam logic [5:0] OP_BGE   = 6'd8;
  localparam logic [5:0] OP_BLTU  = 6'd9;
  localparam logic [5:0] OP_BGEU  = 6'd10;
  localparam logic [5:0] OP_ADDI  = 6'd19;
  localparam logic [5:0] OP_SLTI  = 6'd20;
  localparam logic [5:0] OP_SLTIU = 6'd21;
  localparam logic [5:0] OP_XORI  = 6'd22;
  localparam logic [5:0] OP_ORI   = 6'd23;
  localparam logic [5:0] OP_ANDI  = 6'd24;
  localparam logic [5:0] OP_SLLI  = 6'd25;
  localparam logic [5:0] OP_SRLI  = 6'd26;
  localparam logic [5:0] OP_SRAI  = 6'd27;
  localparam logic [5:0] OP_ADD   = 6'd28;
  localparam logic [5:0] OP_SUB   = 6'd29;
  localparam logic [5:0] OP_SLL   = 6'd30;
  localparam logic [5:0] OP_SLT   = 6'd31;
  localparam logic [5:0] OP_SLTU  = 6'd32;
  localparam logic [5:0] OP_XOR   = 6'd33;
  localparam logic [5:0] OP_SRL   = 6'd34;
  localparam logic [5:0] OP_SRA   = 6'd35;
  localparam logic [5:0] OP_OR    = 6'd36;
  localparam logic [5:0] OP_AND   = 6'd37;

  // Operands seen by the compute stage
  logic               w_valid;
  logic [5:0]         w_op;
  logic [31:0]        w_vj;
  logic [31:0]        w_vk;
  logic [31:0]        w_imm;
  logic [31:0]        w_pc;
  logic [ENTRY_W-1:0] w_entry;
  logic               w_busy_next;

  // The raw instruction rides along for debug only; nothing in this unit consumes it
  logic w_unused_instr;
  assign w_unused_instr = ^rs_instruct_out;

`ifdef ALU_PIPE_EN
  logic               r_s1_valid;
  logic [5:0]         r_s1_op;
  logic [31:0]        r_s1_vj;
  logic [31:0]        r_s1_vk;
  logic [31:0]        r_s1_imm;
  logic [31:0]        r_s1_pc;
  logic [ENTRY_W-1:0] r_s1_entry;

  // S1: capture the issue bundle; rollback drops both the held op and a same-cycle issue
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_vj    <= '0;
      r_s1_vk    <= '0;
      r_s1_imm   <= '0;
      r_s1_pc    <= '0;
      r_s1_entry <= ENTRY_NULL;
    end else if (roll_back) begin
      r_s1_valid <= 1'b0;
    end else if (rdy_in) begin
      r_s1_valid <= new_calculate;
      if (new_calculate) begin
        r_s1_op    <= rs_op_out;
        r_s1_vj    <= rs_vj_out;
        r_s1_vk    <= rs_vk_out;
        r_s1_imm   <= rs_imm_out;
        r_s1_pc    <= rs_pc_out;
        r_s1_entry <= rs_entry_out;
      end
    end
  end

  assign w_valid     = r_s1_valid;
  assign w_op        = r_s1_op;
  assign w_vj        = r_s1_vj;
  assign w_vk        = r_s1_vk;
  assign w_imm       = r_s1_imm;
  assign w_pc        = r_s1_pc;
  assign w_entry     = r_s1_entry;
  // After the edge S1 holds the new issue and S2 holds what S1 held
  assign w_busy_next = new_calculate | r_s1_valid;
`else
  assign w_valid     = new_calculate;
  assign w_op        = rs_op_out;
  assign w_vj        = rs_vj_out;
  assign w_vk        = rs_vk_out;
  assign w_imm       = rs_imm_out;
  assign w_pc        = rs_pc_out;
  assign w_entry     = rs_entry_out;
  assign w_busy_next = new_calculate;
`endif

  logic        w_use_imm;
  logic [31:0] w_op2;
  logic [4:0]  w_shamt;
  logic        w_lt_s;
  logic        w_lt_u;
  logic        w_eq;
  logic [31:0] w_sra;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_plus_imm;
  logic [31:0] w_jalr_target;
  logic        w_is_branch;
  logic        w_taken;
  logic [31:0] w_value;
  logic [31:0] w_npc;
  logic        w_jump;

  // I-type ALU ops take the immediate as second operand, everything else takes vk
  always_comb begin
    w_use_imm = 1'b0;
    case (w_op)
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
      OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI: w_use_imm = 1'b1;
      default:                            w_use_imm = 1'b0;
    endcase
  end

  assign w_op2         = w_use_imm ? w_imm : w_vk;
  assign w_shamt       = w_op2[4:0];
  assign w_lt_s        = $signed(w_vj) < $signed(w_op2);
  assign w_lt_u        = w_vj < w_op2;
  assign w_eq          = w_vj == w_op2;
  assign w_sra         = $signed(w_vj) >>> w_shamt;
  assign w_pc_plus4    = w_pc + 32'd4;
  assign w_pc_plus_imm = w_pc + w_imm;
  assign w_jalr_target = (w_vj + w_imm) & ~32'd1;

  // Branch condition evaluation
  always_comb begin
    w_is_branch = 1'b0;
    w_taken     = 1'b0;
    case (w_op)
      OP_BEQ:  begin w_is_branch = 1'b1; w_taken = w_eq;    end
      OP_BNE:  begin w_is_branch = 1'b1; w_taken = !w_eq;   end
      OP_BLT:  begin w_is_branch = 1'b1; w_taken = w_lt_s;  end
      OP_BGE:  begin w_is_branch = 1'b1; w_taken = !w_lt_s; end
      OP_BLTU: begin w_is_branch = 1'b1; w_taken = w_lt_u;  end
      OP_BGEU: begin w_is_branch = 1'b1; w_taken = !w_lt_u; end
      default: begin w_is_branch = 1'b0; w_taken = 1'b0;    end
    endcase
  end

  // Result, next PC and jump flag; unknown ops produce zero and fall through to pc+4
  always_comb begin
    w_value = '0;
    w_npc   = w_pc_plus4;
    w_jump  = 1'b0;
    case (w_op)
      OP_LUI:   w_value = w_imm;
      OP_AUIPC: w_value = w_pc_plus_imm;
      OP_JAL: begin
        w_value = w_pc_plus4;
        w_npc   = w_pc_plus_imm;
        w_jump  = 1'b1;
      end
      OP_JALR: begin
        w_value = w_pc_plus4;
        w_npc   = w_jalr_target;
        w_jump  = 1'b1;
      end
      OP_ADD, OP_ADDI:   w_value = w_vj + w_op2;
      OP_SUB:            w_value = w_vj - w_op2;
      OP_SLL, OP_SLLI:   w_value = w_vj << w_shamt;
      OP_SRL, OP_SRLI:   w_value = w_vj >> w_shamt;
      OP_SRA, OP_SRAI:   w_value = w_sra;
      OP_SLT, OP_SLTI:   w_value = {31'b0, w_lt_s};
      OP_SLTU, OP_SLTIU: w_value = {31'b0, w_lt_u};
      OP_XOR, OP_XORI:   w_value = w_vj ^ w_op2;
      OP_OR, OP_ORI:     w_value = w_vj | w_op2;
      OP_AND, OP_ANDI:   w_value = w_vj & w_op2;
      default: begin
        if (w_is_branch) begin
          w_value = {31'b0, w_taken};
          w_npc   = w_taken ? w_pc_plus_imm : w_pc_plus4;
          w_jump  = w_taken;
        end
      end
    endcase
  end

  // S2: CDB output registers; data only reloads on a valid op, jump never outlives its broadcast
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      alu_broadcast <= 1'b0;
      alu_entry     <= ENTRY_NULL;
      alu_value     <= '0;
      alu_pc_out    <= '0;
      alu_jump      <= 1'b0;
      alu_busy      <= 1'b0;
    end else if (roll_back) begin
      alu_broadcast <= 1'b0;
      alu_entry     <= ENTRY_NULL;
      alu_jump      <= 1'b0;
      alu_busy      <= 1'b0;
    end else if (rdy_in) begin
      alu_broadcast <= w_valid;
      alu_jump      <= w_valid & w_jump;
      alu_busy      <= w_busy_next;
      if (w_valid) begin
        alu_entry  <= w_entry;
        alu_value  <= w_value;
        alu_pc_out <= w_npc;
      end
    end
  end

endmodule
